hazard_controller: RTL and testbench
====================================

# hazard_controller

Hazard and sequencing controller for the 5-stage pipeline around the decode stage. Generates forwarding selects for the decode-stage branch comparator and the execute-stage ALU, fetch/decode stall and execute flush for load-use and branch hazards, and sequences a multi-cycle execute unit (multiply/divide) through a start/done handshake with a watchdog. Also keeps a saturating stall-cycle counter for performance debug.

## Interface
- MULTI_TIMEOUT, 64: max BUSY cycles before the watchdog aborts the multi-cycle op (≥2).
- CNT_W, 16: width of the stall-cycle counter.

- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- RsD, RtD  in  5 each  decode-stage source registers
- RsE, RtE  in  5 each  execute-stage source registers
- WriteRegE, WriteRegM, WriteRegW  in  5 each  destination register per stage
- RegWriteE, RegWriteM, RegWriteW  in  1 each  register-write enable per stage
- MemtoRegE, MemtoRegM  in  1 each  load in E / M
- BranchD  in  1  branch in decode
- MultiE  in  1  instruction in E needs the multi-cycle unit
- MultiDone  in  1  one-cycle pulse from multi-cycle unit, result valid
- ForwardAD, ForwardBD  out  1 each  select ALUOutM for branch comparator operand A/B
- ForwardAE, ForwardBE  out  2 each  ALU operand select: 00 register, 01 ResultW, 10 ALUOutM
- StallF, StallD, StallE  out  1 each  hold PC / IF-ID / ID-EX registers
- FlushE, FlushM  out  1 each  clear control of ID-EX / EX-MEM
- MultiStart  out  1  one-cycle start pulse to multi-cycle unit
- MultiErr  out  1  sticky watchdog error flag
- StallCount  out  CNT_W  cycles with StallF=1, saturating

## Operation
- Register 0 never matches for forwarding or hazard detection.
- ForwardAE = 10 if RsE≠0, RegWriteM, RsE==WriteRegM; else 01 if RsE≠0, RegWriteW, RsE==WriteRegW; else 00. M has priority over W. ForwardBE same using RtE.
- ForwardAD = RsD≠0 & RegWriteM & RsD==WriteRegM; ForwardBD same with RtD.
- lwstall = MemtoRegE & (RtE==RsD | RtE==RtD).
- branchstall = BranchD & ((RegWriteE & (WriteRegE==RsD | WriteRegE==RtD)) | (MemtoRegM & (WriteRegM==RsD | WriteRegM==RtD))), nonzero registers only.
- Multi-cycle FSM, states IDLE, BUSY:
  - IDLE: MultiE=1 → MultiStart=1, go BUSY, busy counter cleared.
  - BUSY: MultiDone=1 → go IDLE. Else counter increments; counter reaching MULTI_TIMEOUT-1 → set MultiErr, go IDLE (op abandoned, pipeline released).
  - MultiDone in IDLE ignored.
- multstall = (IDLE & MultiE) | (BUSY & ~MultiDone & ~timeout).
- StallF = StallD = lwstall | branchstall | multstall. StallE = FlushM = multstall.
- FlushE = (lwstall | branchstall) & ~multstall (E is held, not bubbled, while the multi-cycle op runs).
- StallCount increments each cycle StallF=1; holds at all-ones.
- MultiErr clears only on reset.

## Timing
- All forward/stall/flush outputs combinational from inputs and state; same-cycle effect.
- MultiStart asserted in the first cycle MultiE is seen in IDLE; unit starts at that edge.
- Multi-cycle op with MultiDone in BUSY cycle k: stalls in cycles 0..k-1, released in cycle k; result enters M at end of cycle k.
- Back-to-back: MultiE still 1 in the IDLE cycle after done (new instruction in E) → new MultiStart immediately.
- Timeout: stalls held for MULTI_TIMEOUT cycles total including the IDLE start cycle, released on the timeout cycle.
- Reset (async, any time incl. mid-BUSY): state IDLE, busy counter 0, StallCount 0, MultiErr 0; MultiStart 0 during reset. Combinational outputs follow inputs.

## Test plan
- RAW: RegWriteM=1, WriteRegM=5, RegWriteW=1, WriteRegW=5, RsE=5 → ForwardAE=10; drop RegWriteM → 01; RsE=0 with WriteRegM=0 → 00.
- Load-use: MemtoRegE=1, RtE=3, RsD=3 → StallF=StallD=FlushE=1 for one cycle, StallCount 0→1.
- Branch: BranchD=1, RegWriteE=1, WriteRegE=7, RtD=7 → stall+flush; next cycle hazard in M with RegWriteM only → no stall, ForwardBD=1.
- Multi-cycle: MultiE=1, MultiDone pulsed in 4th BUSY cycle → MultiStart one pulse, StallE/FlushM high 4 cycles, FlushE=0 throughout, simultaneous lwstall does not raise FlushE.
- Watchdog with MULTI_TIMEOUT=8, no MultiDone → stalls released after 8 cycles, MultiErr=1 sticky; later MultiDone in IDLE has no effect.
- Assert rst_n=0 mid-BUSY → immediate IDLE, MultiErr/StallCount 0; StallCount saturation at CNT_W=4 holds 15.

Source files
------------

// File: rtl/hazard_controller_if.sv
// Hazard-unit bundle: source/destination registers and hazard qualifiers in,
// forwarding selects, stall/flush controls and multi-cycle handshake out.
interface hazard_controller_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       RsD, RtD, RsE, RtE;
  logic [4:0]       WriteRegE, WriteRegM, WriteRegW;
  logic             RegWriteE, RegWriteM, RegWriteW;
  logic             MemtoRegE, MemtoRegM;
  logic             BranchD, MultiE, MultiDone;
  logic             ForwardAD, ForwardBD;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, FlushE, FlushM;
  logic             MultiStart, MultiErr;
  logic [CNT_W-1:0] StallCount;

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, MultiE, MultiDone,
    input  ForwardAD, ForwardBD, ForwardAE, ForwardBE,
           StallF, StallD, StallE, FlushE, FlushM,
           MultiStart, MultiErr, StallCount
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, MultiE, MultiDone,
    output ForwardAD, ForwardBD, ForwardAE, ForwardBE,
           StallF, StallD, StallE, FlushE, FlushM,
           MultiStart, MultiErr, StallCount
  );
endinterface

// File: rtl/hazard_controller.sv
// Decode-stage hazard controller: forwarding, load-use/branch stalls, and the
// start/done sequencer with watchdog for the multi-cycle execute unit.
module hazard_controller #(
  parameter int MULTI_TIMEOUT = 64,
  parameter int CNT_W         = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_controller_if.slave  hz
);
  localparam int BW = (MULTI_TIMEOUT > 2) ? $clog2(MULTI_TIMEOUT) : 1;
  localparam logic [BW-1:0] LAST = BW'(MULTI_TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    busy_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic             err_q;
  logic             start, timeout, mult_stall;
  logic             lw_stall, branch_stall, any_stall;

  function automatic logic [1:0] alu_fwd(input logic [4:0] src,
                                         input logic       wr_m,
                                         input logic [4:0] dst_m,
                                         input logic       wr_w,
                                         input logic [4:0] dst_w);
    if (src != 5'd0 && wr_m && src == dst_m)      return 2'b10;
    else if (src != 5'd0 && wr_w && src == dst_w) return 2'b01;
    else                                          return 2'b00;
  endfunction

  function automatic logic dep(input logic [4:0] dst,
                               input logic [4:0] a,
                               input logic [4:0] b);
    return (dst != 5'd0) && (dst == a || dst == b);
  endfunction

  assign hz.ForwardAE = alu_fwd(hz.RsE, hz.RegWriteM, hz.WriteRegM, hz.RegWriteW, hz.WriteRegW);
  assign hz.ForwardBE = alu_fwd(hz.RtE, hz.RegWriteM, hz.WriteRegM, hz.RegWriteW, hz.WriteRegW);
  assign hz.ForwardAD = (hz.RsD != 5'd0) && hz.RegWriteM && (hz.RsD == hz.WriteRegM);
  assign hz.ForwardBD = (hz.RtD != 5'd0) && hz.RegWriteM && (hz.RtD == hz.WriteRegM);

  assign lw_stall     = hz.MemtoRegE && dep(hz.RtE, hz.RsD, hz.RtD);
  assign branch_stall = hz.BranchD &&
                        ((hz.RegWriteE && dep(hz.WriteRegE, hz.RsD, hz.RtD)) ||
                         (hz.MemtoRegM && dep(hz.WriteRegM, hz.RsD, hz.RtD)));

  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    timeout    = 1'b0;
    mult_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (hz.MultiE) begin
          start      = 1'b1;
          mult_stall = 1'b1;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        timeout = !hz.MultiDone && (busy_cnt == LAST);
        if (hz.MultiDone || timeout) state_d    = IDLE;
        else                         mult_stall = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_cnt  <= '0;
      err_q     <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state_q <= state_d;
      // Counter restarts on every entry into BUSY so each op gets a full window.
      if (state_q == BUSY && state_d == BUSY) busy_cnt <= busy_cnt + 1'b1;
      else                                    busy_cnt <= '0;
      if (timeout) err_q <= 1'b1;
      if (any_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign any_stall     = lw_stall || branch_stall || mult_stall;
  assign hz.StallF     = any_stall;
  assign hz.StallD     = any_stall;
  assign hz.StallE     = mult_stall;
  assign hz.FlushM     = mult_stall;
  // E holds the multi-cycle instruction, so it must not be bubbled meanwhile.
  assign hz.FlushE     = (lw_stall || branch_stall) && !mult_stall;
  assign hz.MultiStart = start && rst_n;
  assign hz.MultiErr   = err_q;
  assign hz.StallCount = stall_cnt;
endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: expectations queued per cycle by the
// stimulus, popped and compared by a negedge monitor.
module tb_hazard_controller;
  localparam int MT = 8;
  localparam int CW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_controller_if #(.CNT_W(CW)) hz ();

  hazard_controller #(.MULTI_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  typedef struct {
    int fad, fbd, fae, fbe, st, fe, se, ms, merr, cnt;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   vec    = 0;

  task automatic chk(input string nm, input int v, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL vec%0d %s: got %0d expected %0d", v, nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("ForwardAD",  vec, int'(hz.ForwardAD),  e.fad);
      chk("ForwardBD",  vec, int'(hz.ForwardBD),  e.fbd);
      chk("ForwardAE",  vec, int'(hz.ForwardAE),  e.fae);
      chk("ForwardBE",  vec, int'(hz.ForwardBE),  e.fbe);
      chk("StallF",     vec, int'(hz.StallF),     e.st);
      chk("StallD",     vec, int'(hz.StallD),     e.st);
      chk("FlushE",     vec, int'(hz.FlushE),     e.fe);
      chk("StallE",     vec, int'(hz.StallE),     e.se);
      chk("FlushM",     vec, int'(hz.FlushM),     e.se);
      chk("MultiStart", vec, int'(hz.MultiStart), e.ms);
      chk("MultiErr",   vec, int'(hz.MultiErr),   e.merr);
      chk("StallCount", vec, int'(hz.StallCount), e.cnt);
      vec++;
    end
  end

  function automatic exp_t mk(input int fad, input int fbd, input int fae, input int fbe,
                              input int st, input int fe, input int se, input int ms,
                              input int merr, input int cnt);
    exp_t e;
    e.fad = fad; e.fbd = fbd; e.fae = fae; e.fbe = fbe; e.st = st;
    e.fe = fe; e.se = se; e.ms = ms; e.merr = merr; e.cnt = cnt;
    return e;
  endfunction

  task automatic clr();
    hz.RsD = 5'd0; hz.RtD = 5'd0; hz.RsE = 5'd0; hz.RtE = 5'd0;
    hz.WriteRegE = 5'd0; hz.WriteRegM = 5'd0; hz.WriteRegW = 5'd0;
    hz.RegWriteE = 1'b0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
    hz.MemtoRegE = 1'b0; hz.MemtoRegM = 1'b0;
    hz.BranchD = 1'b0; hz.MultiE = 1'b0; hz.MultiDone = 1'b0;
  endtask

  task automatic step(input exp_t e);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d expectations pending", q.size());
    $fatal(1, "bench time limit");
  end

  initial begin
    clr();
    hz.MultiE = 1'b1;
    @(posedge clk);
    #1;
    // Reset held: state/counters cleared, MultiStart gated, comb stall follows MultiE.
    step(mk(0,0,0,0, 1,0,1,0, 0,0));
    rst_n = 1'b1;

    // RAW forwarding: M over W, then W, then register 0.
    clr(); hz.RegWriteM = 1; hz.WriteRegM = 5; hz.RegWriteW = 1; hz.WriteRegW = 5; hz.RsE = 5;
    step(mk(0,0,2,0, 0,0,0,0, 0,0));
    hz.RegWriteM = 0;
    step(mk(0,0,1,0, 0,0,0,0, 0,0));
    clr(); hz.RtE = 5; hz.RegWriteM = 1; hz.WriteRegM = 0; hz.RegWriteW = 1; hz.WriteRegW = 5;
    step(mk(0,0,0,1, 0,0,0,0, 0,0));

    // Load-use for one cycle, counter 0 -> 1.
    clr(); hz.MemtoRegE = 1; hz.RtE = 3; hz.RsD = 3;
    step(mk(0,0,0,0, 1,1,0,0, 0,0));
    clr();
    step(mk(0,0,0,0, 0,0,0,0, 0,1));

    // Branch on an E producer, then the same producer in M forwards instead.
    clr(); hz.BranchD = 1; hz.RegWriteE = 1; hz.WriteRegE = 7; hz.RtD = 7;
    step(mk(0,0,0,0, 1,1,0,0, 0,1));
    clr(); hz.BranchD = 1; hz.RegWriteM = 1; hz.WriteRegM = 7; hz.RtD = 7;
    step(mk(0,1,0,0, 0,0,0,0, 0,2));

    // Load with RtE=0 never stalls; M/W both hit RsE -> M wins; ForwardAD hit.
    clr(); hz.MemtoRegE = 1; hz.RsD = 4; hz.RegWriteM = 1; hz.WriteRegM = 4;
    hz.RegWriteW = 1; hz.WriteRegW = 4; hz.RsE = 4;
    step(mk(1,0,2,0, 0,0,0,0, 0,2));

    // Branch behind a load in M stalls.
    clr(); hz.BranchD = 1; hz.MemtoRegM = 1; hz.RegWriteM = 1; hz.WriteRegM = 6; hz.RsD = 6;
    step(mk(1,0,0,0, 1,1,0,0, 0,2));

    // Multi-cycle op, done in 4th BUSY cycle; simultaneous load-use keeps FlushE low.
    clr(); hz.MultiE = 1; hz.MemtoRegE = 1; hz.RtE = 3; hz.RsD = 3;
    step(mk(0,0,0,0, 1,0,1,1, 0,3));
    clr(); hz.MultiE = 1;
    step(mk(0,0,0,0, 1,0,1,0, 0,4));
    step(mk(0,0,0,0, 1,0,1,0, 0,5));
    step(mk(0,0,0,0, 1,0,1,0, 0,6));
    hz.MultiDone = 1;
    step(mk(0,0,0,0, 0,0,0,0, 0,7));
    // Back-to-back op restarts immediately, done in its first BUSY cycle.
    hz.MultiDone = 0;
    step(mk(0,0,0,0, 1,0,1,1, 0,7));
    hz.MultiDone = 1;
    step(mk(0,0,0,0, 0,0,0,0, 0,8));
    clr(); hz.MultiDone = 1;
    step(mk(0,0,0,0, 0,0,0,0, 0,8));

    // Watchdog: no done, stalls for MT cycles total, counter saturates at 15.
    clr(); hz.MultiE = 1;
    step(mk(0,0,0,0, 1,0,1,1, 0,8));
    for (int i = 0; i < MT - 1; i++)
      step(mk(0,0,0,0, 1,0,1,0, 0, (9 + i > 15) ? 15 : 9 + i));
    step(mk(0,0,0,0, 0,0,0,0, 0,15));
    clr(); hz.MultiDone = 1;
    step(mk(0,0,0,0, 0,0,0,0, 1,15));
    clr();
    step(mk(0,0,0,0, 0,0,0,0, 1,15));

    // Further stalls hold the saturated counter.
    hz.MemtoRegE = 1; hz.RtE = 3; hz.RsD = 3;
    step(mk(0,0,0,0, 1,1,0,0, 1,15));
    step(mk(0,0,0,0, 1,1,0,0, 1,15));
    clr();
    step(mk(0,0,0,0, 0,0,0,0, 1,15));

    // Async reset in the middle of BUSY.
    hz.MultiE = 1;
    step(mk(0,0,0,0, 1,0,1,1, 1,15));
    step(mk(0,0,0,0, 1,0,1,0, 1,15));
    rst_n = 1'b0; clr();
    step(mk(0,0,0,0, 0,0,0,0, 0,0));
    rst_n = 1'b1;
    step(mk(0,0,0,0, 0,0,0,0, 0,0));
    hz.MultiE = 1;
    step(mk(0,0,0,0, 1,0,1,1, 0,0));
    clr();

    for (int i = 0; i < 4 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
